rc_accum: RTL and testbench

- Parametrised sequential successor of the two-input AND/OR network.
- Takes operand pairs (x, y) of WIDTH bits each over a valid/ready handshake.
- Combines each pair bitwise (AND into z, OR into w) and accumulates across a burst of NPAIRS pairs.
- Presents the registered result with a done flag that is held until acknowledged; used as a multi-cycle reduction unit behind a simple producer.

---
 rtl/rc_accum_if.sv | 30 +++
 rtl/rc_accum.sv | 95 +++++++++
 tb/tb_rc_accum.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rc_accum_if.sv
// Operand/result bundle for rc_accum.
// Handshake: a beat (x, y) transfers on a rising clock edge where
// in_valid and in_ready are both 1; otherwise nothing is transferred.
// done is a level held until a clock edge that samples ack=1.
interface rc_accum_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] w;
    logic [7:0]       count;
    logic             done;
    logic             ack;

    // Producer/consumer side: drives requests and operands, reads results.
    modport master (
        output start, x, y, in_valid, ack,
        input  in_ready, z, w, count, done
    );

    // Reduction unit side.
    modport slave (
        input  start, x, y, in_valid, ack,
        output in_ready, z, w, count, done
    );
endinterface

// File: rtl/rc_accum.sv
// Multi-cycle bitwise AND/OR reduction over a burst of NPAIRS operand pairs.
// z accumulates AND of all operands, w accumulates OR; result is held with
// done=1 until acknowledged. state_dbg exposes the FSM state
// (0=IDLE, 1=ACC, 2=DONE).
module rc_accum #(
    parameter int WIDTH  = 8,
    parameter int NPAIRS = 4
) (
    input  logic       clock,
    input  logic       reset_,
    rc_accum_if.slave  bus,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // count index of the final beat of a burst
    localparam logic [7:0] LAST = 8'(NPAIRS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [7:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             done_q, done_d;

    // Next-state and datapath: outputs are derived from the next state so
    // in_ready/done are registered and line up with the state they describe.
    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        w_d     = w_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACC;
                    z_d     = '1;
                    w_d     = '0;
                    count_d = 8'd0;
                end
            end
            ACC: begin
                // in_ready is 1 throughout ACC, so in_valid alone accepts
                if (bus.in_valid) begin
                    z_d     = z_q & (bus.x & bus.y);
                    w_d     = w_q | (bus.x | bus.y);
                    count_d = count_q + 8'd1;
                    if (count_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == ACC);
        done_d     = (state_d == DONE);
    end

    // FSM and result registers; reset discards any partial burst.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q    <= IDLE;
            z_q        <= '1;
            w_q        <= '0;
            count_q    <= 8'd0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            z_q        <= z_d;
            w_q        <= w_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    assign bus.z        = z_q;
    assign bus.w        = w_q;
    assign bus.count    = count_q;
    assign bus.in_ready = in_ready_q;
    assign bus.done     = done_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_rc_accum.sv
// Directed bench for rc_accum: a vector table for reset, a full burst and
// protocol abuse, then hand-written sequences for gaps, mid-burst reset and
// the single-bit degenerate configuration.
module tb_rc_accum;
    logic clock;
    logic reset_;
    logic [1:0] st8;
    logic [1:0] st1;

    rc_accum_if #(.WIDTH(8)) bus8 ();
    rc_accum_if #(.WIDTH(1)) bus1 ();

    rc_accum #(.WIDTH(8), .NPAIRS(4)) dut8 (
        .clock     (clock),
        .reset_    (reset_),
        .bus       (bus8.slave),
        .state_dbg (st8)
    );

    rc_accum #(.WIDTH(1), .NPAIRS(1)) dut1 (
        .clock     (clock),
        .reset_    (reset_),
        .bus       (bus1.slave),
        .state_dbg (st1)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       in_valid;
        logic       ack;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] ez;
        logic [7:0] ew;
        logic [7:0] ec;
        logic       edone;
        logic       erdy;
        logic [1:0] est;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic r, logic s, logic iv, logic a,
                               logic [7:0] x, logic [7:0] y,
                               logic [7:0] ez, logic [7:0] ew, logic [7:0] ec,
                               logic ed, logic er, logic [1:0] es);
        vec_t t;
        t.rst_n = r;  t.start = s; t.in_valid = iv; t.ack = a;
        t.x = x;      t.y = y;
        t.ez = ez;    t.ew = ew;   t.ec = ec;
        t.edone = ed; t.erdy = er; t.est = es;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive8(logic s, logic iv, logic a, logic [7:0] x, logic [7:0] y);
        bus8.start = s; bus8.in_valid = iv; bus8.ack = a; bus8.x = x; bus8.y = y;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk8(string name, logic [7:0] ez, logic [7:0] ew, logic [7:0] ec,
                        logic ed, logic er);
        check({name, ".z"}, 32'(bus8.z), 32'(ez));
        check({name, ".w"}, 32'(bus8.w), 32'(ew));
        check({name, ".count"}, 32'(bus8.count), 32'(ec));
        check({name, ".done"}, 32'(bus8.done), 32'(ed));
        check({name, ".in_ready"}, 32'(bus8.in_ready), 32'(er));
    endtask

    logic [7:0] bx[4];
    logic [7:0] by[4];
    logic [7:0] mz;
    logic [7:0] mw;

    initial begin
        reset_ = 1'b0;
        drive8(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.ack = 1'b0;
        bus1.x = 1'b0; bus1.y = 1'b0;

        bx[0] = 8'hF0; by[0] = 8'hFF;
        bx[1] = 8'hFF; by[1] = 8'h3C;
        bx[2] = 8'hFF; by[2] = 8'hFF;
        bx[3] = 8'hF8; by[3] = 8'hFF;

        //          rst st iv ak x      y      z      w      cnt  dn rdy st
        vecs.push_back(v(0, 1, 1, 0, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'd0, 0, 0, 2'd0));
        vecs.push_back(v(0, 1, 1, 0, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 0, 1, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 0, 0, 1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 1, 0, 1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'd0, 0, 1, 2'd1));
        vecs.push_back(v(1, 1, 1, 1, 8'hF0, 8'hFF, 8'hF0, 8'hFF, 8'd1, 0, 1, 2'd1));
        vecs.push_back(v(1, 1, 1, 1, 8'hFF, 8'h3C, 8'h30, 8'hFF, 8'd2, 0, 1, 2'd1));
        vecs.push_back(v(1, 1, 0, 0, 8'h00, 8'h00, 8'h30, 8'hFF, 8'd2, 0, 1, 2'd1));
        vecs.push_back(v(1, 1, 1, 0, 8'hFF, 8'hFF, 8'h30, 8'hFF, 8'd3, 0, 1, 2'd1));
        vecs.push_back(v(1, 1, 1, 0, 8'hF8, 8'hFF, 8'h30, 8'hFF, 8'd4, 1, 0, 2'd2));
        vecs.push_back(v(1, 1, 1, 0, 8'h00, 8'h00, 8'h30, 8'hFF, 8'd4, 1, 0, 2'd2));
        vecs.push_back(v(1, 1, 1, 0, 8'h00, 8'h00, 8'h30, 8'hFF, 8'd4, 1, 0, 2'd2));
        vecs.push_back(v(1, 1, 1, 1, 8'h00, 8'h00, 8'h30, 8'hFF, 8'd4, 0, 0, 2'd0));
        vecs.push_back(v(1, 0, 1, 0, 8'h00, 8'h00, 8'h30, 8'hFF, 8'd4, 0, 0, 2'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset_ = vecs[i].rst_n;
            drive8(vecs[i].start, vecs[i].in_valid, vecs[i].ack, vecs[i].x, vecs[i].y);
            step();
            chk8($sformatf("vec%0d", i), vecs[i].ez, vecs[i].ew, vecs[i].ec,
                 vecs[i].edone, vecs[i].erdy);
            check($sformatf("vec%0d.state", i), 32'(st8), 32'(vecs[i].est));
        end

        // gaps: three idle cycles before each beat, count moves only on accepts
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        chk8("gap.start", 8'hFF, 8'h00, 8'd0, 1'b0, 1'b1);
        mz = 8'hFF;
        mw = 8'h00;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 3; g++) begin
                drive8(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
                step();
                check($sformatf("gap%0d_%0d.count", b, g), 32'(bus8.count), 32'(b));
            end
            drive8(1'b0, 1'b1, 1'b0, bx[b], by[b]);
            step();
            mz = mz & bx[b] & by[b];
            mw = mw | bx[b] | by[b];
            check($sformatf("gap_beat%0d.count", b), 32'(bus8.count), 32'(b + 1));
            check($sformatf("gap_beat%0d.z", b), 32'(bus8.z), 32'(mz));
        end
        drive8(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk8("gap.done", 8'h30, 8'hFF, 8'd4, 1'b1, 1'b0);
        drive8(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step();
        chk8("gap.ack", 8'h30, 8'hFF, 8'd4, 1'b0, 1'b0);

        // reset in the middle of a burst
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        drive8(1'b0, 1'b1, 1'b0, 8'h0F, 8'hFF);
        step();
        drive8(1'b0, 1'b1, 1'b0, 8'hFF, 8'h0F);
        step();
        check("mid.pre_count", 32'(bus8.count), 32'd2);
        reset_ = 1'b0;
        drive8(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        step();
        reset_ = 1'b1;
        chk8("mid.reset", 8'hFF, 8'h00, 8'd0, 1'b0, 1'b0);
        check("mid.state", 32'(st8), 32'd0);
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        drive8(1'b0, 1'b1, 1'b0, 8'h0F, 8'hFF);
        step();
        drive8(1'b0, 1'b1, 1'b0, 8'h1F, 8'h8F);
        step();
        drive8(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        step();
        drive8(1'b0, 1'b1, 1'b0, 8'h2F, 8'h4F);
        step();
        chk8("mid.rerun", 8'h0F, 8'hFF, 8'd4, 1'b1, 1'b0);
        drive8(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step();
        drive8(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // single-bit, single-pair configuration: all four operand pairs
        for (int k = 0; k < 4; k++) begin
            logic xb;
            logic yb;
            xb = 1'(k >> 1);
            yb = 1'(k);
            bus1.start = 1'b1;
            step();
            bus1.start = 1'b0;
            bus1.in_valid = 1'b1;
            bus1.x = xb;
            bus1.y = yb;
            step();
            bus1.in_valid = 1'b0;
            check($sformatf("w1_%0d.z", k), 32'(bus1.z), 32'(k == 3));
            check($sformatf("w1_%0d.w", k), 32'(bus1.w), 32'(k != 0));
            check($sformatf("w1_%0d.done", k), 32'(bus1.done), 32'd1);
            check($sformatf("w1_%0d.count", k), 32'(bus1.count), 32'd1);
            bus1.ack = 1'b1;
            step();
            bus1.ack = 1'b0;
            check($sformatf("w1_%0d.ackdone", k), 32'(bus1.done), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
